// File: rtl/debounce_bank.sv
//==============================================================================
// Module      : debounce_bank
// Description : Multi-channel switch debouncer with a shared prescaler tick,
//               registered rise/fall event pulses and a long-press hold flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_bank #(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = 20,
    parameter int   TICK_DIV       = 1,
    parameter int   HOLD_LIMIT     = 0,
    parameter logic INIT_STATE     = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_bouncy,
    output logic [NUM_CH-1:0] o_debounced,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_hold
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_LIMIT - 1);

    logic w_tick;

    generate
        if (TICK_DIV == 1) begin : g_tick_every_clk
            assign w_tick = 1'b1;
        end else begin : g_prescaler
            localparam int                 c_PRE_W   = $clog2(TICK_DIV);
            localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

            logic [c_PRE_W-1:0] r_pre;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pre <= '0;
                end else if (r_pre == c_PRE_MAX) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end

            assign w_tick = (r_pre == c_PRE_MAX);
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic               r_s1;
            logic               r_s2;
            logic               r_state;
            logic               r_rise;
            logic               r_fall;
            logic [c_CNT_W-1:0] r_cnt;
            logic               w_flip;
            logic               w_state_nxt;

            assign w_flip      = (r_s2 != r_state) && w_tick && (r_cnt == c_CNT_MAX);
            assign w_state_nxt = w_flip ? r_s2 : r_state;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s1 <= INIT_STATE;
                    r_s2 <= INIT_STATE;
                end else begin
                    r_s1 <= i_bouncy[i];
                    r_s2 <= r_s1;
                end
            end

            // Any clock of agreement discards the partial count, ticked or not.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt   <= '0;
                    r_state <= INIT_STATE;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_rise  <= w_flip &  r_s2;
                    r_fall  <= w_flip & ~r_s2;
                    if ((r_s2 == r_state) || w_flip) begin
                        r_cnt <= '0;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign o_debounced[i] = r_state;
            assign o_rise[i]      = r_rise;
            assign o_fall[i]      = r_fall;

            if (HOLD_LIMIT > 0) begin : g_hold
                localparam int                  c_HOLD_W   = $clog2(HOLD_LIMIT + 1);
                localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_LIMIT);

                logic [c_HOLD_W-1:0] r_hcnt;
                logic [c_HOLD_W-1:0] w_hcnt_nxt;
                logic                r_hold;

                always_comb begin
                    w_hcnt_nxt = r_hcnt;
                    if (!r_state) begin
                        w_hcnt_nxt = '0;
                    end else if (w_tick && (r_hcnt != c_HOLD_MAX)) begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end

                // Gating with the next state drops hold on the same edge as the fall pulse.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_hcnt <= '0;
                        r_hold <= 1'b0;
                    end else begin
                        r_hcnt <= w_hcnt_nxt;
                        r_hold <= w_state_nxt && (w_hcnt_nxt == c_HOLD_MAX);
                    end
                end

                assign o_hold[i] = r_hold;
            end else begin : g_no_hold
                assign o_hold[i] = 1'b0;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
//==============================================================================
// Module      : tb_debounce_bank
// Description : Scoreboard bench for debounce_bank; expected output changes are
//               queued by stimulus and matched by a per-clock monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_debounce_bank;

    logic       clk;
    logic       rst0_n, rst1_n;
    logic [3:0] b0, b1;
    logic [3:0] deb0, rise0, fall0, hold0;
    logic [3:0] deb1, rise1, fall1, hold1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int r0     = 0;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] prev0 = 16'h0000;
    logic [15:0] prev1 = 16'hF000;

    debounce_bank #(
        .NUM_CH(4), .DEBOUNCE_LIMIT(4), .TICK_DIV(1), .HOLD_LIMIT(8), .INIT_STATE(1'b0)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .i_bouncy(b0),
        .o_debounced(deb0), .o_rise(rise0), .o_fall(fall0), .o_hold(hold0)
    );

    debounce_bank #(
        .NUM_CH(4), .DEBOUNCE_LIMIT(4), .TICK_DIV(4), .HOLD_LIMIT(8), .INIT_STATE(1'b1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_bouncy(b1),
        .o_debounced(deb1), .o_rise(rise1), .o_fall(fall1), .o_hold(hold1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input int c, input logic [3:0] deb,
                        input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] hold);
        exp_t e;
        e.cyc = c;
        e.vec = {deb, rise, fall, hold};
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic mon(input int d, input logic [15:0] obs);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        while (sz > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.cyc >= cyc) break;
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            checks++;
            errors++;
            $display("FAIL sb%0d_missing cyc=%0d got=%h want=%h at cyc %0d", d, cyc, obs, e.vec, e.cyc);
            sz--;
        end
        if (obs !== ((d == 0) ? prev0 : prev1)) begin
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL sb%0d_unexpected cyc=%0d got=%h want=no change", d, cyc, obs);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if ((e.cyc != cyc) || (e.vec !== obs)) begin
                    errors++;
                    $display("FAIL sb%0d_change cyc=%0d got=%h want=%h at cyc %0d", d, cyc, obs, e.vec, e.cyc);
                end
            end
        end
        if (d == 0) prev0 = obs;
        else        prev1 = obs;
    endtask

    always @(negedge clk) begin
        mon(0, {deb0, rise0, fall0, hold0});
        mon(1, {deb1, rise1, fall1, hold1});
    end

    task automatic thread0();
        int e, f, g, h, k;
        // clean step and hold on ch0
        step();
        e = cyc;
        b0[0] = 1'b1;
        push(0, e + 6,  4'h1, 4'h1, 4'h0, 4'h0);
        push(0, e + 7,  4'h1, 4'h0, 4'h0, 4'h0);
        push(0, e + 14, 4'h1, 4'h0, 4'h0, 4'h1);
        repeat (18) step();
        f = cyc;
        b0[0] = 1'b0;
        push(0, f + 6, 4'h0, 4'h0, 4'h1, 4'h0);
        push(0, f + 7, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (10) step();
        // glitches on ch1 that must be discarded
        repeat (5) begin
            b0[1] = 1'b1;
            repeat (3) step();
            b0[1] = 1'b0;
            repeat (3) step();
        end
        repeat (6) step();
        g = cyc;
        b0[1] = 1'b1;
        push(0, g + 6,  4'h2, 4'h2, 4'h0, 4'h0);
        push(0, g + 7,  4'h2, 4'h0, 4'h0, 4'h0);
        push(0, g + 10, 4'h0, 4'h0, 4'h2, 4'h0);
        push(0, g + 11, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (4) step();
        b0[1] = 1'b0;
        repeat (12) step();
        // reset while ch0 holds and ch2 is mid-count
        h = cyc;
        b0[0] = 1'b1;
        push(0, h + 6,  4'h1, 4'h1, 4'h0, 4'h0);
        push(0, h + 7,  4'h1, 4'h0, 4'h0, 4'h0);
        push(0, h + 14, 4'h1, 4'h0, 4'h0, 4'h1);
        repeat (12) step();
        b0[2] = 1'b1;
        repeat (4) step();
        push(0, cyc, 4'h0, 4'h0, 4'h0, 4'h0);
        rst0_n = 1'b0;
        #1;
        chk("async_reset", {deb0, rise0, fall0, hold0}, 16'h0000);
        repeat (2) step();
        k = cyc;
        rst0_n = 1'b1;
        push(0, k + 6,  4'h5, 4'h5, 4'h0, 4'h0);
        push(0, k + 7,  4'h5, 4'h0, 4'h0, 4'h0);
        push(0, k + 14, 4'h5, 4'h0, 4'h0, 4'h5);
        repeat (18) step();
    endtask

    task automatic thread1();
        int s, t1;
        while (cyc < r0 + 36) step();
        s = cyc;
        b1 = 4'h0;
        t1 = s + 3;
        while (((t1 - r0) % 4) != 0) t1++;
        push(1, t1 + 12, 4'h0, 4'h0, 4'hF, 4'h0);
        push(1, t1 + 13, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (24) step();
    endtask

    initial begin
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        b0     = 4'hF;
        b1     = 4'hF;
        #1;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (5) begin
            step();
            chk("reset_dut0", {deb0, rise0, fall0, hold0}, 16'h0000);
            chk("reset_dut1", {deb1, rise1, fall1, hold1}, 16'hF000);
        end
        b0     = 4'h0;
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        r0     = cyc;
        // INIT_STATE=1 channels start high, so hold matures after 8 prescaled ticks
        push(1, r0 + 32, 4'hF, 4'h0, 4'h0, 4'hF);
        repeat (3) begin
            step();
            chk("release_dut0", {deb0, rise0, fall0, hold0}, 16'h0000);
            chk("release_dut1", {deb1, rise1, fall1, hold1}, 16'hF000);
        end
        fork
            thread0();
            thread1();
        join
        repeat (4) step();
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL sb0_leftover got=%0d want=0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL sb1_leftover got=%0d want=0", q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel, parametrised debouncer for mechanical switch and button inputs.
- Each channel has a 2-flop synchroniser, a stability counter driven by a shared prescaler tick, registered edge-event pulses and a long-press (hold) flag.
- Sits between raw board pins and control FSMs/LED logic.
- Replaces per-pin single-channel debounce instances with one bank.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- DEBOUNCE_LIMIT, 20: consecutive ticks of disagreement needed to accept a new level (>=2).
- TICK_DIV, 1: prescaler divide ratio; counters advance once per TICK_DIV clocks (>=1; 1 = every clock).
- HOLD_LIMIT, 0: ticks a channel must stay debounced-high before o_hold asserts; 0 disables hold detection.
- INIT_STATE, 0: reset value of every synchroniser flop and debounced state bit (1-bit, applied to all channels).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_bouncy  input  NUM_CH  raw asynchronous switch inputs, one bit per channel.
- o_debounced  output  NUM_CH  debounced level per channel.
- o_rise  output  NUM_CH  one-clock pulse when the debounced level goes 0->1.
- o_fall  output  NUM_CH  one-clock pulse when the debounced level goes 1->0.
- o_hold  output  NUM_CH  level; high while the channel has been debounced-high for >= HOLD_LIMIT ticks.

Behaviour:
- Reset (i_rst_n low, asynchronous, any time including mid-count):
  - sync flops, o_debounced = INIT_STATE;
  - o_rise, o_fall, o_hold = 0;
  - all counters and the prescaler = 0.
- Release is sampled on the next i_clk edge.
- All outputs are registered; no combinational path from i_bouncy to any output.
- Prescaler: free-running 0..TICK_DIV-1, wraps to 0. Internal tick is high in the cycle where the count is TICK_DIV-1. With TICK_DIV=1 the tick is always high. One prescaler is shared by all channels.
- Synchroniser: i_bouncy -> s1 -> s2, two i_clk flops per channel. Only s2 feeds channel logic.
- Stability counter, per channel, width $clog2(DEBOUNCE_LIMIT). Each clock:
  - s2 == state: count <= 0. This applies on every clock, not only on ticks, so a glitch shorter than the limit is fully discarded.
  - s2 != state, tick high, count == DEBOUNCE_LIMIT-1: state <= s2, count <= 0.
  - s2 != state, tick high, otherwise: count <= count+1.
  - s2 != state, tick low: count holds.
  - The counter never exceeds DEBOUNCE_LIMIT-1; no wrap.
- Latency (TICK_DIV=1): a clean step is visible on o_debounced 2+DEBOUNCE_LIMIT clock edges after the input changes.
- Edge pulses:
  - o_rise[i] is high for exactly one clock, the first clock in which o_debounced[i] reads 1 after reading 0. o_fall[i] is the mirror.
  - Never both high at once.
  - No pulse is produced by reset or reset release.
- Hold counter, per channel, saturating, width $clog2(HOLD_LIMIT+1):
  - Cleared while state == 0.
  - Increments on ticks while state == 1; it counts only from the clock after the rise.
  - o_hold[i] goes high on the clock the count reaches HOLD_LIMIT and stays high until state falls.
  - o_hold clears in the same clock that o_fall pulses.
  - HOLD_LIMIT=0: o_hold is tied to 0 and no hold logic is generated.
- Channel independence: simultaneous activity on several channels is handled fully in parallel; no arbitration and no shared counter other than the prescaler.

Test Plan:
All scenarios use NUM_CH=4, DEBOUNCE_LIMIT=4, TICK_DIV=1, HOLD_LIMIT=8, INIT_STATE=0 unless stated.

1. Reset: hold i_rst_n low 5 clocks with i_bouncy=4'hF -> o_debounced=0, o_rise=o_fall=o_hold=0. Release -> no pulse on the release edge.
2. Clean step: i_bouncy[0] 0->1 just before edge 1, held -> o_debounced[0]=1 from edge 6; o_rise[0]=1 only in that cycle; other channels stay 0.
3. Glitch reject: i_bouncy[1] high for 3 clocks then low, repeated 5 times -> o_debounced[1] never changes, no pulses. Then a 4-clock high pulse (internally stable for 4 clocks) -> o_debounced[1] rises.
4. Hold/fall: after step 2, keep ch0 high -> o_hold[0] rises 8 clocks after o_debounced[0]. Drop i_bouncy[0] -> o_debounced[0]=0 6 edges later, o_fall[0] pulses once, and o_hold[0] clears in the same cycle.
5. Prescaler and parallelism: TICK_DIV=4, INIT_STATE=1, all four inputs step 1->0 together -> all four o_debounced fall in the same cycle, between 2+13 and 2+16 clocks after the step; one o_fall per channel.
6. Reset mid-operation: assert i_rst_n low while ch2 count=2 and ch0 o_hold=1 -> all outputs return to reset values asynchronously, with no o_fall pulse. After release, ch2 needs a full 4 ticks to flip again.
